pattern_scan_ctrl: RTL and testbench

Frame sequencer for the serial 1010 pattern detector (Moore, overlapping, synchronous active-high reset, output high while in its final state).
- Accepts a frame of N parallel words over a valid/ready interface and serialises them MSB-first onto the detector's x input, one bit per clock.
- Counts detector hits across the frame, including hits that span word boundaries.
- Holds the detector in reset between frames and reports the hit count with a done pulse.

---
 rtl/pattern_scan_ctrl_pkg.sv | 15 +
 rtl/pattern_scan_ctrl_hit_counter.sv | 29 ++
 rtl/pattern_scan_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_scan_ctrl_pkg.sv
// Shared types and defaults for the 1010 detector frame sequencer.
package pattern_scan_ctrl_pkg;

   localparam int unsigned WORD_W_DEF = 8;
   localparam int unsigned CNT_W_DEF  = 8;
   localparam int unsigned ACC_W      = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DRAIN = 2'd3
   } scan_state_e;

endpackage

// File: rtl/pattern_scan_ctrl_hit_counter.sv
// Saturating hit counter with synchronous clear; never wraps.
module scan_hit_counter
   import pattern_scan_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_clr,
   input  logic             i_en,
   output logic [CNT_W-1:0] o_count
);

   logic [CNT_W-1:0] r_count;

   // Clear wins over increment; increment stops at all-ones.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en && (r_count != {CNT_W{1'b1}})) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Frame sequencer: serialises N words MSB-first into the 1010 detector and counts its hits.
module pattern_scan_ctrl
   import pattern_scan_ctrl_pkg::*;
#(
   parameter int unsigned WORD_W = WORD_W_DEF,
   parameter int unsigned CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [7:0]        num_words,
   input  logic              in_valid,
   input  logic [WORD_W-1:0] in_data,
   output logic              in_ready,
   output logic              det_x,
   output logic              det_reset,
   input  logic              det_hit,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  hit_count,
   output logic              underrun
);

   localparam int unsigned BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);

   scan_state_e       r_state;
   logic [ACC_W-1:0]  r_n;
   logic [ACC_W-1:0]  r_accepted;
   logic [BIT_W-1:0]  r_bit_cnt;
   logic [WORD_W-1:0] r_shreg;
   logic [WORD_W-1:0] r_hold;
   logic              r_hold_full;
   logic              r_in_ready;
   logic              r_det_reset;
   logic              r_busy;
   logic              r_done;
   logic              r_underrun;
   logic              r_bit_v_d;

   scan_state_e       w_state_nxt;
   logic [ACC_W-1:0]  w_acc_nxt;
   logic              w_hold_full_nxt;
   logic              w_fire;
   logic              w_last;
   logic              w_load_in;
   logic              w_load_hold;
   logic              w_to_hold;
   logic              w_clr_frame;
   logic              w_clr_hit;
   logic              w_set_underrun;
   logic              w_ready_nxt;

   assign w_fire = in_valid & r_in_ready;
   assign w_last = (r_bit_cnt == '0);

   // Next-state and datapath steering decisions.
   always_comb begin
      w_state_nxt     = r_state;
      w_acc_nxt       = r_accepted;
      w_hold_full_nxt = r_hold_full;
      w_load_in       = 1'b0;
      w_load_hold     = 1'b0;
      w_to_hold       = 1'b0;
      w_clr_frame     = 1'b0;
      w_clr_hit       = 1'b0;
      w_set_underrun  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_clr_hit = 1'b1;
               if (num_words != 8'd0) begin
                  w_clr_frame = 1'b1;
                  w_acc_nxt   = '0;
                  w_state_nxt = ST_FILL;
               end else begin
                  w_state_nxt = ST_DRAIN;
               end
            end
         end
         ST_FILL: begin
            if (w_fire) begin
               w_load_in   = 1'b1;
               w_acc_nxt   = r_accepted + ACC_W'(1);
               w_state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (w_last) begin
               // Priority: held word, then bypass, then frame end, else bubble.
               if (r_hold_full) begin
                  w_load_hold     = 1'b1;
                  w_hold_full_nxt = 1'b0;
               end else if (w_fire) begin
                  w_load_in = 1'b1;
                  w_acc_nxt = r_accepted + ACC_W'(1);
               end else if (r_accepted == r_n) begin
                  w_state_nxt = ST_DRAIN;
               end else begin
                  w_state_nxt    = ST_FILL;
                  w_set_underrun = 1'b1;
               end
            end else if (w_fire) begin
               w_to_hold       = 1'b1;
               w_hold_full_nxt = 1'b1;
               w_acc_nxt       = r_accepted + ACC_W'(1);
            end
         end
         ST_DRAIN: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      w_ready_nxt = (w_state_nxt == ST_FILL) ||
                    ((w_state_nxt == ST_SHIFT) && !w_hold_full_nxt && (w_acc_nxt < r_n));
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_n         <= '0;
         r_accepted  <= '0;
         r_bit_cnt   <= '0;
         r_shreg     <= '0;
         r_hold      <= '0;
         r_hold_full <= 1'b0;
         r_in_ready  <= 1'b0;
         r_det_reset <= 1'b1;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_underrun  <= 1'b0;
         r_bit_v_d   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_accepted  <= w_acc_nxt;
         r_hold_full <= w_hold_full_nxt;
         r_in_ready  <= w_ready_nxt;
         r_det_reset <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_FILL);
         r_busy      <= (w_state_nxt != ST_IDLE);
         r_done      <= (r_state == ST_DRAIN);
         r_bit_v_d   <= (r_state == ST_SHIFT);
         if (w_clr_frame) begin
            r_n        <= num_words;
            r_underrun <= 1'b0;
         end
         if (w_set_underrun) begin
            r_underrun <= 1'b1;
         end
         // Shift register empties to zero, so det_x is 0 outside SHIFT.
         if (w_load_in) begin
            r_shreg   <= in_data;
            r_bit_cnt <= BIT_LAST;
         end else if (w_load_hold) begin
            r_shreg   <= r_hold;
            r_bit_cnt <= BIT_LAST;
         end else if (r_state == ST_SHIFT) begin
            r_shreg   <= {r_shreg[WORD_W-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt - BIT_W'(1);
         end
         if (w_to_hold) begin
            r_hold <= in_data;
         end
      end
   end

   scan_hit_counter #(
      .CNT_W (CNT_W)
   ) u_hits (
      .clk     (clk),
      .reset_n (reset_n),
      .i_clr   (w_clr_hit),
      .i_en    (det_hit & r_bit_v_d),
      .o_count (hit_count)
   );

   assign in_ready  = r_in_ready;
   assign det_x     = r_shreg[WORD_W-1];
   assign det_reset = r_det_reset;
   assign busy      = r_busy;
   assign done      = r_done;
   assign underrun  = r_underrun;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: directed frames plus random frames against a bit-stream model.
module tb_pattern_scan_ctrl;

   localparam int unsigned WORD_W = 8;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              start;
   logic [7:0]        num_words;
   logic              in_valid;
   logic [WORD_W-1:0] in_data;

   logic              in_ready, det_x, det_reset, det_hit, busy, done, underrun;
   logic [7:0]        hit_count;
   logic              sat_in_ready, sat_det_x, sat_det_reset, sat_det_hit;
   logic              sat_busy, sat_done, sat_underrun;
   logic [1:0]        sat_hit_count;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   int det_st     = 0;
   int sat_det_st = 0;

   bit obs_bits[$];
   bit obs_seg[$];
   bit prev_rst = 1'b1;
   int done_cnt  = 0;
   int ready_cnt = 0;

   logic [7:0] fw[$];
   int         fg[$];
   bit         fb[$];

   pattern_scan_ctrl #(.WORD_W(WORD_W), .CNT_W(8)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .num_words (num_words),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .det_x     (det_x),
      .det_reset (det_reset),
      .det_hit   (det_hit),
      .busy      (busy),
      .done      (done),
      .hit_count (hit_count),
      .underrun  (underrun)
   );

   pattern_scan_ctrl #(.WORD_W(WORD_W), .CNT_W(2)) u_sat (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .num_words (num_words),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (sat_in_ready),
      .det_x     (sat_det_x),
      .det_reset (sat_det_reset),
      .det_hit   (sat_det_hit),
      .busy      (sat_busy),
      .done      (sat_done),
      .hit_count (sat_hit_count),
      .underrun  (sat_underrun)
   );

   always #5 clk = ~clk;

   // Moore overlapping 1010 detector; state 4 means "1010" just seen.
   function automatic int det_next(input int s, input logic x);
      case (s)
         0:       return x ? 1 : 0;
         1:       return x ? 1 : 2;
         2:       return x ? 3 : 0;
         3:       return x ? 1 : 4;
         4:       return x ? 3 : 0;
         default: return 0;
      endcase
   endfunction

   always @(posedge clk) begin
      if (det_reset) det_st <= 0;
      else           det_st <= det_next(det_st, det_x);
   end
   always @(posedge clk) begin
      if (sat_det_reset) sat_det_st <= 0;
      else               sat_det_st <= det_next(sat_det_st, sat_det_x);
   end
   assign det_hit     = (det_st == 4);
   assign sat_det_hit = (sat_det_st == 4);

   // Reference: count "1010" windows that lie wholly inside one unbroken bit run.
   function automatic int ref_hits(input bit b[$], input bit s[$]);
      int h;
      h = 0;
      for (int i = 0; i + 3 < b.size(); i++) begin
         if (!(s[i+1] || s[i+2] || s[i+3]))
            if (b[i] && !b[i+1] && b[i+2] && !b[i+3]) h++;
      end
      return h;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic sample();
      if (busy && !det_reset) begin
         obs_bits.push_back(det_x);
         obs_seg.push_back(prev_rst);
      end
      prev_rst = det_reset;
      if (done) done_cnt++;
      if (in_ready) ready_cnt++;
   endtask

   task automatic tick();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic add_word(input logic [7:0] w, input int g, input bit bub);
      fw.push_back(w);
      fg.push_back(g);
      fb.push_back(bub);
   endtask

   task automatic clear_frame();
      fw.delete();
      fg.delete();
      fb.delete();
   endtask

   task automatic run_frame(input int n, input bit spam);
      bit eb[$];
      bit es[$];
      int exp_h, exp_segs, c_s, guard, mism, os;
      bit all0, exp_under, lastb;
      obs_bits.delete();
      obs_seg.delete();
      done_cnt  = 0;
      ready_cnt = 0;
      all0      = 1'b1;
      exp_under = 1'b0;
      exp_segs  = (n > 0) ? 1 : 0;
      for (int k = 0; k < n; k++) begin
         for (int b = WORD_W - 1; b >= 0; b--) begin
            eb.push_back(fw[k][b]);
            es.push_back((b == WORD_W - 1) && ((k == 0) || fb[k]));
         end
         if (fg[k] != 0) all0 = 1'b0;
         if (k > 0 && fb[k]) begin
            exp_under = 1'b1;
            exp_segs++;
         end
      end
      exp_h = ref_hits(eb, es);

      num_words = 8'(n);
      start     = 1'b1;
      tick();
      c_s       = cyc;
      start     = spam;
      num_words = 8'(n ^ 3);
      for (int k = 0; k < n; k++) begin
         in_valid = 1'b0;
         repeat (fg[k]) tick();
         in_valid = 1'b1;
         in_data  = fw[k];
         guard    = 0;
         while (!in_ready && guard < 100) begin
            tick();
            guard++;
         end
         chk($sformatf("accept_w%0d", k), 32'(in_ready), 32'd1);
         if (in_ready) tick();
      end
      in_valid  = 1'b0;
      start     = 1'b0;
      num_words = 8'd0;
      guard     = 0;
      while (!done && guard < 8 * n + 400) begin
         tick();
         guard++;
      end
      chk("done_seen", 32'(done), 32'd1);
      if (all0) chk("latency", 32'(cyc - c_s), (n == 0) ? 32'd1 : 32'(8 * n + 2));
      if (obs_bits.size() > 0) begin
         lastb = obs_bits.pop_back();
         void'(obs_seg.pop_back());
         chk("drain_x", 32'(lastb), 32'd0);
      end
      chk("bit_count", 32'(obs_bits.size()), 32'(8 * n));
      mism = 0;
      for (int i = 0; i < eb.size() && i < obs_bits.size(); i++)
         if (eb[i] !== obs_bits[i]) mism++;
      chk("bit_stream", 32'(mism), 32'd0);
      chk("hit_count", 32'(hit_count), 32'((exp_h > 255) ? 255 : exp_h));
      chk("hit_count_sat", 32'(sat_hit_count), 32'((exp_h > 3) ? 3 : exp_h));
      chk("sat_done", 32'(sat_done), 32'd1);
      chk("busy_at_done", 32'(busy), 32'd0);
      if (n > 0) begin
         os = 0;
         foreach (obs_seg[i]) os += int'(obs_seg[i]);
         chk("segments", 32'(os), 32'(exp_segs));
         chk("underrun", 32'(underrun), 32'(exp_under));
         chk("sat_underrun", 32'(sat_underrun), 32'(exp_under));
      end else begin
         chk("ready_never", 32'(ready_cnt), 32'd0);
      end
      tick();
      chk("done_pulse", 32'(done), 32'd0);
      chk("done_count", 32'(done_cnt), 32'd1);
      chk("hit_hold", 32'(hit_count), 32'((exp_h > 255) ? 255 : exp_h));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, guard;
      logic [7:0] w;
      reset_n   = 1'b0;
      start     = 1'b0;
      num_words = 8'd0;
      in_valid  = 1'b0;
      in_data   = '0;
      repeat (3) tick();
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_det_reset", 32'(det_reset), 32'd1);
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      chk("rst_det_x",     32'(det_x),     32'd0);
      chk("rst_hit",       32'(hit_count), 32'd0);
      chk("rst_done",      32'(done),      32'd0);
      chk("rst_underrun",  32'(underrun),  32'd0);
      reset_n = 1'b1;
      repeat (2) tick();

      // Single 0xAA word, always valid.
      clear_frame();
      add_word(8'hAA, 0, 1'b0);
      run_frame(1, 1'b0);
      chk("t1_hits", 32'(hit_count), 32'd3);
      chk("t1_under", 32'(underrun), 32'd0);

      // Hits across a word boundary.
      clear_frame();
      add_word(8'h0A, 0, 1'b0);
      add_word(8'hA0, 0, 1'b0);
      run_frame(2, 1'b0);
      chk("t2_hits", 32'(hit_count), 32'd3);

      // Bubble of 3 cycles after the first word: straddling hit lost.
      clear_frame();
      add_word(8'h0A, 0, 1'b0);
      add_word(8'hA0, 10, 1'b1);
      run_frame(2, 1'b0);
      chk("t3_hits", 32'(hit_count), 32'd2);
      chk("t3_under", 32'(underrun), 32'd1);

      // Empty frame.
      clear_frame();
      run_frame(0, 1'b0);
      chk("t4_hits", 32'(hit_count), 32'd0);

      // Seven raw hits, narrow counter saturates; start held while busy.
      clear_frame();
      add_word(8'hAA, 0, 1'b0);
      add_word(8'hAA, 0, 1'b0);
      run_frame(2, 1'b1);
      chk("t5_hits", 32'(hit_count), 32'd7);
      chk("t5_sat", 32'(sat_hit_count), 32'd3);
      chk("t5_idle", 32'(busy), 32'd0);

      // Async reset in the middle of shifting.
      done_cnt  = 0;
      num_words = 8'd2;
      start     = 1'b1;
      tick();
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'hAA;
      guard    = 0;
      while (!in_ready && guard < 20) begin
         tick();
         guard++;
      end
      tick();
      repeat (6) tick();
      #2;
      reset_n = 1'b0;
      #1;
      chk("mid_busy",      32'(busy),          32'd0);
      chk("mid_det_reset", 32'(det_reset),     32'd1);
      chk("mid_det_x",     32'(det_x),         32'd0);
      chk("mid_in_ready",  32'(in_ready),      32'd0);
      chk("mid_hit",       32'(hit_count),     32'd0);
      chk("mid_done",      32'(done),          32'd0);
      chk("mid_sat_ready", 32'(sat_in_ready),  32'd0);
      chk("mid_sat_busy",  32'(sat_busy),      32'd0);
      in_valid = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      repeat (3) tick();
      chk("mid_no_done", 32'(done_cnt), 32'd0);
      clear_frame();
      add_word(8'h5A, 0, 1'b0);
      add_word(8'hA5, 0, 1'b0);
      run_frame(2, 1'b0);

      // Random frames: gaps of 0 never bubble, gaps of 17+ always do.
      for (int f = 0; f < 24; f++) begin
         clear_frame();
         n = (($urandom % 10) == 0) ? 0 : int'($urandom_range(1, 6));
         for (int k = 0; k < n; k++) begin
            case ($urandom % 4)
               0:       w = 8'hAA;
               1:       w = 8'h0A;
               2:       w = 8'h55;
               default: w = 8'($urandom);
            endcase
            if (k == 0)
               add_word(w, int'($urandom_range(0, 3)), 1'b0);
            else if (($urandom % 4) == 0)
               add_word(w, 17 + int'($urandom_range(0, 4)), 1'b1);
            else
               add_word(w, 0, 1'b0);
         end
         run_frame(n, 1'($urandom % 2));
         repeat (int'($urandom_range(0, 2))) tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
